// File: rtl/chroma_pkg.sv
// Shared types and constants for the chroma-key threshold calibrator.
package chroma_pkg;

    localparam int PIX_W      = 10;
    localparam int DEFAULT_TH = 512;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACCUM,
        COMPUTE,
        DONE
    } state_t;

    // Wide enough to sum every window pixel of every averaged frame without overflow.
    function automatic int acc_width(input int wx_log2, input int wy_log2, input int nf_log2);
        return PIX_W + wx_log2 + wy_log2 + nf_log2;
    endfunction

endpackage

// File: rtl/chroma_key_calibrator_if.sv
// Video input bus (frame marker, pixel valid, coordinates and RGB) feeding the calibrator.
interface chroma_key_calibrator_if;
    import chroma_pkg::*;

    logic             iSOF;
    logic             iDVAL;
    logic [PIX_W-1:0] iX;
    logic [PIX_W-1:0] iY;
    logic [PIX_W-1:0] iRed;
    logic [PIX_W-1:0] iGreen;
    logic [PIX_W-1:0] iBlue;

    modport master (output iSOF, iDVAL, iX, iY, iRed, iGreen, iBlue);
    modport slave  (input  iSOF, iDVAL, iX, iY, iRed, iGreen, iBlue);

endinterface

// File: rtl/chroma_win_accum.sv
// Single-channel window accumulator; the mean is the sum shifted right by SHIFT.
module chroma_win_accum
    import chroma_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] mean
);

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(din);
        end
    end

    assign mean = acc[SHIFT +: PIX_W];

endmodule

// File: rtl/chroma_key_calibrator.sv
// Averages R/G/B over a fixed window for several frames and registers the
// compositor's green threshold (mean green minus a margin, saturating at zero).
module chroma_key_calibrator
    import chroma_pkg::*;
#(
    parameter int WIN_X0     = 288,
    parameter int WIN_Y0     = 208,
    parameter int WX_LOG2    = 6,
    parameter int WY_LOG2    = 6,
    parameter int NF_LOG2    = 2,
    parameter int MARGIN     = 64,
    parameter int DEFAULT_TH = chroma_pkg::DEFAULT_TH
) (
    input  logic                   iCLK27,
    input  logic                   iRST_N,
    input  logic                   iStart,
    chroma_key_calibrator_if.slave vid,
    output logic [PIX_W-1:0]       oThG,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oErr
);

    localparam int PC_LOG2 = WX_LOG2 + WY_LOG2;
    localparam int SHIFT   = PC_LOG2 + NF_LOG2;
    localparam int ACC_W   = acc_width(WX_LOG2, WY_LOG2, NF_LOG2);
    localparam int X_END   = WIN_X0 + (1 << WX_LOG2);
    localparam int Y_END   = WIN_Y0 + (1 << WY_LOG2);
    localparam logic [PC_LOG2:0] PIX_FULL = {1'b1, {PC_LOG2{1'b0}}};
    localparam logic [NF_LOG2:0] FRM_FULL = {1'b1, {NF_LOG2{1'b0}}};

    state_t           state, state_nx;
    logic [PC_LOG2:0] pcnt;
    logic [NF_LOG2:0] fcnt;
    logic             in_win, frame_ok, last_frame, is_green;
    logic             acc_clr, acc_en, pcnt_restart, fcnt_clr, fcnt_inc, err_set, th_load;
    logic [PIX_W-1:0] mean_r, mean_g, mean_b, max_rb, th_new;

    assign in_win = vid.iDVAL
                 && (32'(vid.iX) >= WIN_X0) && (32'(vid.iX) < X_END)
                 && (32'(vid.iY) >= WIN_Y0) && (32'(vid.iY) < Y_END);

    assign frame_ok   = (pcnt == PIX_FULL);
    assign last_frame = ((fcnt + (NF_LOG2+1)'(1)) == FRM_FULL);

    chroma_win_accum #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_acc_r (
        .clk(iCLK27), .rst_n(iRST_N), .clr(acc_clr), .en(acc_en), .din(vid.iRed),   .mean(mean_r)
    );
    chroma_win_accum #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_acc_g (
        .clk(iCLK27), .rst_n(iRST_N), .clr(acc_clr), .en(acc_en), .din(vid.iGreen), .mean(mean_g)
    );
    chroma_win_accum #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_acc_b (
        .clk(iCLK27), .rst_n(iRST_N), .clr(acc_clr), .en(acc_en), .din(vid.iBlue),  .mean(mean_b)
    );

    assign max_rb   = (mean_r > mean_b) ? mean_r : mean_b;
    assign is_green = (mean_g > max_rb);
    assign th_new   = (32'(mean_g) > MARGIN) ? (mean_g - PIX_W'(MARGIN)) : '0;

    always_ff @(posedge iCLK27 or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A pixel arriving with iSOF belongs to the frame that iSOF opens, so it is
    // accumulated after the check unless that iSOF closes the last frame.
    always_comb begin
        state_nx     = state;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        pcnt_restart = 1'b0;
        fcnt_clr     = 1'b0;
        fcnt_inc     = 1'b0;
        err_set      = 1'b0;
        th_load      = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    acc_clr  = 1'b1;
                    state_nx = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (vid.iSOF) begin
                    fcnt_clr     = 1'b1;
                    pcnt_restart = 1'b1;
                    acc_en       = in_win;
                    state_nx     = ACCUM;
                end
            end
            ACCUM: begin
                if (vid.iSOF) begin
                    if (!frame_ok) begin
                        err_set  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        fcnt_inc = 1'b1;
                        if (last_frame) begin
                            state_nx = COMPUTE;
                        end else begin
                            pcnt_restart = 1'b1;
                            acc_en       = in_win;
                        end
                    end
                end else begin
                    acc_en = in_win;
                end
            end
            COMPUTE: begin
                if (is_green) begin
                    th_load = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
                state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pixel counter saturates so an oversized frame can never wrap back to a valid count.
    always_ff @(posedge iCLK27 or negedge iRST_N) begin
        if (!iRST_N) begin
            pcnt <= '0;
            fcnt <= '0;
        end else begin
            if (acc_clr || fcnt_clr) begin
                fcnt <= '0;
            end else if (fcnt_inc) begin
                fcnt <= fcnt + (NF_LOG2+1)'(1);
            end
            if (acc_clr) begin
                pcnt <= '0;
            end else if (pcnt_restart) begin
                pcnt <= (PC_LOG2+1)'(acc_en);
            end else if (acc_en && (pcnt != '1)) begin
                pcnt <= pcnt + (PC_LOG2+1)'(1);
            end
        end
    end

    always_ff @(posedge iCLK27 or negedge iRST_N) begin
        if (!iRST_N) begin
            oThG <= PIX_W'(DEFAULT_TH);
            oErr <= 1'b0;
        end else begin
            if (acc_clr) begin
                oErr <= 1'b0;
            end else if (err_set) begin
                oErr <= 1'b1;
            end
            if (th_load) begin
                oThG <= th_new;
            end
        end
    end

    assign oBusy = (state == WAIT_SOF) || (state == ACCUM) || (state == COMPUTE);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_chroma_key_calibrator.sv
// Bench: default-size calibrator for the full-window scenarios, a small-window
// instance for table vectors and randomized runs against a transaction-level model.
module tb_chroma_key_calibrator;
    import chroma_pkg::*;

    localparam int BX0 = 288, BY0 = 208, BW = 64, BH = 64;
    localparam int SX0 = 3, SY0 = 2, SW = 4, SH = 4, SNF = 2, SMARGIN = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_b = 1'b0, start_s = 1'b0;
    logic [9:0] th_b, th_s;
    logic       busy_b, done_b, err_b, busy_s, done_s, err_s;

    int checks = 0, errors = 0;
    int cyc = 0;
    int done_cnt_b = 0, done_cnt_s = 0, done_cyc_s = 0;

    // transaction-level model of the small instance
    bit     m_on = 0, m_open = 0, m_err = 0;
    int     m_cnt = 0, m_nfr = 0, m_th = 512, m_fin_cyc = 0;
    longint m_sr = 0, m_sg = 0, m_sb = 0;

    typedef struct { int r; int g; int b; int th; int err; } vec_t;
    vec_t tbl[7];

    chroma_key_calibrator_if vid();

    chroma_key_calibrator u_big (
        .iCLK27(clk), .iRST_N(rst_n), .iStart(start_b), .vid(vid),
        .oThG(th_b), .oBusy(busy_b), .oDone(done_b), .oErr(err_b)
    );

    chroma_key_calibrator #(
        .WIN_X0(SX0), .WIN_Y0(SY0), .WX_LOG2(2), .WY_LOG2(2), .NF_LOG2(1),
        .MARGIN(SMARGIN), .DEFAULT_TH(512)
    ) u_small (
        .iCLK27(clk), .iRST_N(rst_n), .iStart(start_s), .vid(vid),
        .oThG(th_s), .oBusy(busy_s), .oDone(done_s), .oErr(err_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_s) begin
            done_cnt_s <= done_cnt_s + 1;
            done_cyc_s <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_start();
        m_on = 1; m_open = 0; m_err = 0; m_cnt = 0; m_nfr = 0;
        m_sr = 0; m_sg = 0; m_sb = 0;
    endfunction

    function automatic void model_finish();
        int n, mr, mg, mb, mx;
        n  = SW * SH * SNF;
        mr = int'(m_sr / n);
        mg = int'(m_sg / n);
        mb = int'(m_sb / n);
        mx = (mr > mb) ? mr : mb;
        if (mg <= mx) m_err = 1;
        else m_th = (mg > SMARGIN) ? mg - SMARGIN : 0;
    endfunction

    function automatic void model_beat(input bit sof, input bit dval, input int x, y, r, g, b);
        if (!m_on) return;
        if (sof) begin
            if (m_open) begin
                if (m_cnt != SW * SH) begin
                    m_err = 1; m_on = 0; m_fin_cyc = cyc + 1;
                    return;
                end
                m_nfr++;
                if (m_nfr == SNF) begin
                    model_finish(); m_on = 0; m_fin_cyc = cyc + 2;
                    return;
                end
            end
            m_open = 1;
            m_cnt  = 0;
        end
        if (m_open && dval && x >= SX0 && x < SX0 + SW && y >= SY0 && y < SY0 + SH) begin
            m_sr += r; m_sg += g; m_sb += b;
            m_cnt++;
        end
    endfunction

    task automatic beat(input bit sof, input bit dval, input int x, y, r, g, b);
        vid.iSOF   = sof;
        vid.iDVAL  = dval;
        vid.iX     = 10'(x);
        vid.iY     = 10'(y);
        vid.iRed   = 10'(r);
        vid.iGreen = 10'(g);
        vid.iBlue  = 10'(b);
        model_beat(sof, dval, x, y, r, g, b);
        tick();
        vid.iSOF  = 1'b0;
        vid.iDVAL = 1'b0;
    endtask

    function automatic int pv(input int base, input int noise);
        int v;
        v = base + ((noise > 0) ? int'($urandom_range(0, noise)) : 0);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic big_frame(input int r, g, b, input bit drop_last, input bit edges);
        if (edges) begin
            beat(0, 1, BX0 - 1,  BY0,      1023, 0, 1023);
            beat(0, 1, BX0 + BW, BY0,      1023, 0, 1023);
            beat(0, 1, BX0 + 5,  BY0 + BH, 1023, 0, 1023);
            beat(0, 0, BX0 + 5,  BY0 + 5,  1023, 0, 1023);
        end
        for (int y = BY0; y < BY0 + BH - (drop_last ? 1 : 0); y++)
            for (int x = BX0; x < BX0 + BW; x++)
                beat(0, 1, x, y, r, g, b);
    endtask

    task automatic small_run(input int rb, gb, bb, input int noise, input bit wild);
        int d0, mode;
        start_s = 1'b1;
        beat(0, 0, 0, 0, 0, 0, 0);
        start_s = 1'b0;
        model_start();
        chk("small_busy_after_start", busy_s, 1);
        d0   = done_cnt_s;
        mode = wild ? int'($urandom_range(0, 3)) : 0;
        for (int f = 0; f <= SNF; f++) begin
            if (wild && $urandom_range(0, 3) == 0)
                beat(1, 1, int'($urandom_range(SX0 - 1, SX0 + SW)), int'($urandom_range(SY0 - 1, SY0 + SH)),
                     pv(rb, noise), pv(gb, noise), pv(bb, noise));
            else
                beat(1, 0, 0, 0, 0, 0, 0);
            if (f < SNF) begin
                for (int y = SY0 - 1; y <= SY0 + SH; y++) begin
                    for (int x = SX0 - 1; x <= SX0 + SW; x++) begin
                        beat(0, !(mode == 1 && f == SNF - 1 && x == SX0 + 1 && y == SY0 + 2),
                             x, y, pv(rb, noise), pv(gb, noise), pv(bb, noise));
                        if (mode == 2 && f == 0 && x == SX0 && y == SY0)
                            beat(0, 1, x, y, pv(rb, noise), pv(gb, noise), pv(bb, noise));
                    end
                end
            end
        end
        repeat (3) beat(0, 0, 0, 0, 0, 0, 0);
        chk("small_done_pulses", done_cnt_s - d0, 1);
        chk("small_done_cycle", done_cyc_s, m_fin_cyc);
        chk("small_thg", th_s, m_th);
        chk("small_err", err_s, m_err);
        chk("small_busy_idle", busy_s, 0);
    endtask

    initial begin
        int d0, rb, gb, bb;
        tbl[0] = '{100, 800,  100,  736, 0};
        tbl[1] = '{600, 500,  100,  736, 1};
        tbl[2] = '{10,  40,   10,   0,   0};
        tbl[3] = '{0,   65,   0,    1,   0};
        tbl[4] = '{300, 300,  0,    1,   1};
        tbl[5] = '{1022, 1023, 1022, 959, 0};
        tbl[6] = '{0,   64,   0,    0,   0};

        vid.iSOF = 0; vid.iDVAL = 0; vid.iX = 0; vid.iY = 0;
        vid.iRed = 0; vid.iGreen = 0; vid.iBlue = 0;

        repeat (3) tick();
        chk("rst_big_thg", th_b, 512);
        chk("rst_big_busy", busy_b, 0);
        chk("rst_big_done", done_b, 0);
        chk("rst_big_err", err_b, 0);
        chk("rst_small_thg", th_s, 512);
        chk("rst_small_busy", busy_s, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // flat green with edge pixels and an ignored second start
        d0 = done_cnt_b;
        start_b = 1'b1;
        beat(0, 0, 0, 0, 0, 0, 0);
        start_b = 1'b0;
        chk("flat_busy", busy_b, 1);
        beat(1, 0, 0, 0, 0, 0, 0);
        for (int f = 0; f < 4; f++) begin
            big_frame(100, 800, 100, 1'b0, f == 1);
            if (f == 0) begin
                start_b = 1'b1;
                beat(0, 0, 0, 0, 0, 0, 0);
                start_b = 1'b0;
            end
            if (f < 3) beat(1, 0, 0, 0, 0, 0, 0);
        end
        chk("flat_busy_before_close", busy_b, 1);
        beat(1, 0, 0, 0, 0, 0, 0);
        chk("flat_done_plus1", done_b, 0);
        chk("flat_thg_plus1", th_b, 512);
        tick();
        chk("flat_done_plus2", done_b, 1);
        chk("flat_busy_plus2", busy_b, 0);
        chk("flat_thg", th_b, 736);
        chk("flat_err", err_b, 0);
        tick();
        chk("flat_done_plus3", done_b, 0);
        chk("flat_done_pulses", done_cnt_b - d0, 1);

        // short second frame
        d0 = done_cnt_b;
        start_b = 1'b1;
        beat(0, 0, 0, 0, 0, 0, 0);
        start_b = 1'b0;
        beat(1, 0, 0, 0, 0, 0, 0);
        big_frame(100, 800, 100, 1'b0, 1'b0);
        beat(1, 0, 0, 0, 0, 0, 0);
        big_frame(300, 300, 300, 1'b1, 1'b0);
        chk("short_err_before", err_b, 0);
        beat(1, 0, 0, 0, 0, 0, 0);
        chk("short_err", err_b, 1);
        chk("short_done", done_b, 1);
        chk("short_thg", th_b, 736);
        tick();
        chk("short_done_off", done_b, 0);
        chk("short_busy", busy_b, 0);
        chk("short_done_pulses", done_cnt_b - d0, 1);

        // table vectors on the small window
        for (int i = 0; i < 7; i++) begin
            small_run(tbl[i].r, tbl[i].g, tbl[i].b, 0, 1'b0);
            chk("tbl_thg", th_s, tbl[i].th);
            chk("tbl_err", err_s, tbl[i].err);
        end

        // randomized runs: noisy colours, dropped/duplicated pixels, pixels on iSOF
        for (int i = 0; i < 24; i++) begin
            gb = int'($urandom_range(0, 1023));
            rb = int'($urandom_range(0, 1023));
            bb = int'($urandom_range(0, 1023));
            if (i % 2 == 0) begin
                rb = rb / 3;
                bb = bb / 3;
            end
            small_run(rb, gb, bb, int'($urandom_range(0, 200)), 1'b1);
        end

        // asynchronous reset in the middle of accumulation
        start_b = 1'b1;
        beat(0, 0, 0, 0, 0, 0, 0);
        start_b = 1'b0;
        beat(1, 0, 0, 0, 0, 0, 0);
        for (int x = BX0; x < BX0 + 60; x++) beat(0, 1, x, BY0, 100, 800, 100);
        chk("midrst_busy_before", busy_b, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_thg", th_b, 512);
        chk("midrst_busy", busy_b, 0);
        chk("midrst_err", err_b, 0);
        chk("midrst_small_thg", th_s, 512);
        tick();
        rst_n = 1'b1;
        beat(1, 0, 0, 0, 0, 0, 0);
        chk("postrst_idle_busy", busy_b, 0);
        chk("postrst_done", done_b, 0);
        start_b = 1'b1;
        beat(0, 0, 0, 0, 0, 0, 0);
        start_b = 1'b0;
        chk("postrst_start_busy", busy_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(1_000_000);
        errors++;
        $display("FAIL watchdog: got cycle %0d without completion, expected finish before 100000", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
